// File: rtl/draw_box_pkg.sv
// find_stars_pkg: screen geometry, coordinate widths and draw_box states.
// Shared by draw_box, box_clamp and draw_box_if.
package find_stars_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COL_W    = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_TOP,
    S_BOTTOM,
    S_LEFT,
    S_RIGHT,
    S_FILL,
    S_DONE
  } db_state_e;
endpackage

// File: rtl/draw_box_if.sv
// draw_box_if: box request from the star FSM and plot bus to the vga_adapter.
// The master drives the request; the slave (draw_box) drives the plot bus.
interface draw_box_if
  import find_stars_pkg::*;
();
  logic             goDraw;
  logic [X_W-1:0]   left;
  logic [X_W-1:0]   right;
  logic [Y_W-1:0]   top;
  logic [Y_W-1:0]   bottom;
  logic [COL_W-1:0] colourIn;
  logic [X_W-1:0]   x;
  logic [Y_W-1:0]   y;
  logic [COL_W-1:0] colour;
  logic             plot;
  logic             doneDraw;

  modport master (
    output goDraw, left, right, top, bottom, colourIn,
    input  x, y, colour, plot, doneDraw
  );

  modport slave (
    input  goDraw, left, right, top, bottom, colourIn,
    output x, y, colour, plot, doneDraw
  );
endinterface

// File: rtl/draw_box_clamp.sv
// box_clamp: orders the box corners, pads by MARGIN and clamps to screen.
// Math runs one bit wider so padding never wraps around.
module box_clamp
  import find_stars_pkg::*;
#(
  parameter int MARGIN = 1
) (
  input  logic [X_W-1:0] i_left,
  input  logic [X_W-1:0] i_right,
  input  logic [Y_W-1:0] i_top,
  input  logic [Y_W-1:0] i_bottom,
  output logic [X_W-1:0] o_l,
  output logic [X_W-1:0] o_r,
  output logic [Y_W-1:0] o_t,
  output logic [Y_W-1:0] o_b
);
  localparam logic [X_W:0] MX   = (X_W+1)'(MARGIN);
  localparam logic [Y_W:0] MY   = (Y_W+1)'(MARGIN);
  localparam logic [X_W:0] XMAX = (X_W+1)'(SCREEN_W-1);
  localparam logic [Y_W:0] YMAX = (Y_W+1)'(SCREEN_H-1);

  logic [X_W:0] w_xlo;
  logic [X_W:0] w_xhi;
  logic [Y_W:0] w_ylo;
  logic [Y_W:0] w_yhi;
  logic [X_W:0] w_l;
  logic [X_W:0] w_r;
  logic [Y_W:0] w_t;
  logic [Y_W:0] w_b;

  assign w_xlo = (i_left > i_right) ?
                 {1'b0, i_right} : {1'b0, i_left};
  assign w_xhi = (i_left > i_right) ?
                 {1'b0, i_left} : {1'b0, i_right};
  assign w_ylo = (i_top > i_bottom) ?
                 {1'b0, i_bottom} : {1'b0, i_top};
  assign w_yhi = (i_top > i_bottom) ?
                 {1'b0, i_top} : {1'b0, i_bottom};

  assign w_l = (w_xlo < MX) ? '0 : w_xlo - MX;
  assign w_t = (w_ylo < MY) ? '0 : w_ylo - MY;
  assign w_r = w_xhi + MX;
  assign w_b = w_yhi + MY;

  assign o_l = (w_l > XMAX) ? XMAX[X_W-1:0] : w_l[X_W-1:0];
  assign o_r = (w_r > XMAX) ? XMAX[X_W-1:0] : w_r[X_W-1:0];
  assign o_t = (w_t > YMAX) ? YMAX[Y_W-1:0] : w_t[Y_W-1:0];
  assign o_b = (w_b > YMAX) ? YMAX[Y_W-1:0] : w_b[Y_W-1:0];
endmodule

// File: rtl/draw_box.sv
// draw_box: plots a box outline (or filled box with DRAW_BOX_FILL_EN)
// into the vga_adapter one pixel per clock, then raises doneDraw.
module draw_box
  import find_stars_pkg::*;
#(
  parameter int MARGIN = 1
) (
  input  logic     clk,
  input  logic     resetn,
  draw_box_if.slave bus
);
  db_state_e        r_state;
  db_state_e        w_ns;
  logic [X_W-1:0]   r_rl;
  logic [X_W-1:0]   r_rr;
  logic [Y_W-1:0]   r_rt;
  logic [Y_W-1:0]   r_rb;
  logic [COL_W-1:0] r_col;
  logic [X_W-1:0]   r_l;
  logic [X_W-1:0]   r_r;
  logic [Y_W-1:0]   r_t;
  logic [Y_W-1:0]   r_b;
  logic [X_W-1:0]   r_cx;
  logic [Y_W-1:0]   r_cy;
  logic [X_W-1:0]   w_ncx;
  logic [Y_W-1:0]   w_ncy;
  logic             w_emit;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [COL_W-1:0] r_colour;
  logic             r_plot;
  logic             r_done;
  logic [X_W-1:0]   w_cl;
  logic [X_W-1:0]   w_cr;
  logic [Y_W-1:0]   w_ct;
  logic [Y_W-1:0]   w_cb;

  box_clamp #(.MARGIN(MARGIN)) u_clamp (
    .i_left   (r_rl),
    .i_right  (r_rr),
    .i_top    (r_rt),
    .i_bottom (r_rb),
    .o_l      (w_cl),
    .o_r      (w_cr),
    .o_t      (w_ct),
    .o_b      (w_cb)
  );

  always_comb begin
    w_ns   = r_state;
    w_ncx  = r_cx;
    w_ncy  = r_cy;
    w_emit = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.goDraw) w_ns = S_LATCH;
      end
      S_LATCH: begin
        w_ncx = w_cl;
        w_ncy = w_ct;
`ifdef DRAW_BOX_FILL_EN
        w_ns  = S_FILL;
`else
        w_ns  = S_TOP;
`endif
      end
`ifdef DRAW_BOX_FILL_EN
      S_FILL: begin
        w_emit = 1'b1;
        if (r_cx != r_r) begin
          w_ncx = r_cx + 1'b1;
        end else if (r_cy == r_b) begin
          w_ns = S_DONE;
        end else begin
          w_ncx = r_l;
          w_ncy = r_cy + 1'b1;
        end
      end
`else
      S_TOP: begin
        w_emit = 1'b1;
        if (r_cx != r_r) begin
          w_ncx = r_cx + 1'b1;
        end else if (r_b == r_t) begin
          w_ns = S_DONE;
        end else begin
          w_ns  = S_BOTTOM;
          w_ncx = r_l;
          w_ncy = r_b;
        end
      end
      S_BOTTOM: begin
        w_emit = 1'b1;
        if (r_cx != r_r) begin
          w_ncx = r_cx + 1'b1;
        end else if ((r_b - r_t) < Y_W'(2)) begin
          w_ns = S_DONE;
        end else begin
          w_ns  = S_LEFT;
          w_ncx = r_l;
          w_ncy = r_t + 1'b1;
        end
      end
      // side columns skip the corner rows already drawn
      S_LEFT: begin
        w_emit = 1'b1;
        if (r_cy != r_b - 1'b1) begin
          w_ncy = r_cy + 1'b1;
        end else if (r_r == r_l) begin
          w_ns = S_DONE;
        end else begin
          w_ns  = S_RIGHT;
          w_ncx = r_r;
          w_ncy = r_t + 1'b1;
        end
      end
      S_RIGHT: begin
        w_emit = 1'b1;
        if (r_cy != r_b - 1'b1) w_ncy = r_cy + 1'b1;
        else w_ns = S_DONE;
      end
`endif
      S_DONE: begin
        if (!bus.goDraw) w_ns = S_IDLE;
      end
      default: w_ns = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_rl     <= '0;
      r_rr     <= '0;
      r_rt     <= '0;
      r_rb     <= '0;
      r_col    <= '0;
      r_l      <= '0;
      r_r      <= '0;
      r_t      <= '0;
      r_b      <= '0;
      r_cx     <= '0;
      r_cy     <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_ns;
      r_cx    <= w_ncx;
      r_cy    <= w_ncy;
      if (r_state == S_IDLE && bus.goDraw) begin
        r_rl  <= bus.left;
        r_rr  <= bus.right;
        r_rt  <= bus.top;
        r_rb  <= bus.bottom;
        r_col <= bus.colourIn;
      end
      if (r_state == S_LATCH) begin
        r_l <= w_cl;
        r_r <= w_cr;
        r_t <= w_ct;
        r_b <= w_cb;
      end
      r_plot <= w_emit;
      if (w_emit) begin
        r_x      <= r_cx;
        r_y      <= r_cy;
        r_colour <= r_col;
      end
      // first DONE cycle always pulses; afterwards follow goDraw
      r_done <= (r_state == S_DONE) &&
                (bus.goDraw || !r_done);
    end
  end

  assign bus.x        = r_x;
  assign bus.y        = r_y;
  assign bus.colour   = r_colour;
  assign bus.plot     = r_plot;
  assign bus.doneDraw = r_done;
endmodule

// File: tb/tb_draw_box.sv
// tb_draw_box: directed box draws on MARGIN=0 and MARGIN=2 instances,
// pixels checked in order against a queue built from the box geometry.
module tb_draw_box;
  import find_stars_pkg::*;

  typedef struct {
    int x;
    int y;
  } px_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  draw_box_if b0 ();
  draw_box_if b2 ();

  draw_box #(.MARGIN(0)) u0 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b0)
  );

  draw_box #(.MARGIN(2)) u2 (
    .clk    (clk),
    .resetn (resetn),
    .bus    (b2)
  );

  int               sel = 0;
  logic             go = 1'b0;
  logic [X_W-1:0]   il = '0;
  logic [X_W-1:0]   ir = '0;
  logic [Y_W-1:0]   it = '0;
  logic [Y_W-1:0]   ib = '0;
  logic [COL_W-1:0] ic = '0;

  assign b0.goDraw   = go && (sel == 0);
  assign b2.goDraw   = go && (sel == 1);
  assign b0.left     = il;
  assign b2.left     = il;
  assign b0.right    = ir;
  assign b2.right    = ir;
  assign b0.top      = it;
  assign b2.top      = it;
  assign b0.bottom   = ib;
  assign b2.bottom   = ib;
  assign b0.colourIn = ic;
  assign b2.colourIn = ic;

  logic [X_W-1:0]   ox;
  logic [Y_W-1:0]   oy;
  logic [COL_W-1:0] oc;
  logic             oplot;
  logic             odone;

  always_comb begin
    ox    = (sel == 0) ? b0.x : b2.x;
    oy    = (sel == 0) ? b0.y : b2.y;
    oc    = (sel == 0) ? b0.colour : b2.colour;
    oplot = (sel == 0) ? b0.plot : b2.plot;
    odone = (sel == 0) ? b0.doneDraw : b2.doneDraw;
  end

  int  npass = 0;
  int  ntot  = 0;
  px_t q[$];

  task automatic chk(input string tag, input int obs, input int exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic void push(input int x, input int y);
    px_t p;
    p.x = x;
    p.y = y;
    q.push_back(p);
  endfunction

  function automatic void build(input int lf, input int rt,
                                input int tp, input int bo,
                                input int m);
    int l0, r0, t0, b0v, L, R, T, B;
    q.delete();
    l0 = (lf > rt) ? rt : lf;
    r0 = (lf > rt) ? lf : rt;
    t0 = (tp > bo) ? bo : tp;
    b0v = (tp > bo) ? tp : bo;
    L = (l0 - m < 0) ? 0 : l0 - m;
    R = (r0 + m > 159) ? 159 : r0 + m;
    T = (t0 - m < 0) ? 0 : t0 - m;
    B = (b0v + m > 119) ? 119 : b0v + m;
`ifdef DRAW_BOX_FILL_EN
    for (int y = T; y <= B; y++)
      for (int x = L; x <= R; x++) push(x, y);
`else
    for (int x = L; x <= R; x++) push(x, T);
    if (B != T) begin
      for (int x = L; x <= R; x++) push(x, B);
      if (B - T >= 2) begin
        for (int y = T + 1; y < B; y++) push(L, y);
        if (R != L)
          for (int y = T + 1; y < B; y++) push(R, y);
      end
    end
`endif
  endfunction

  task automatic run_box(input int s, input int lf, input int rt,
                         input int tp, input int bo, input int col,
                         input int m, input int hold, input bit mid);
    int  n_exp, first, cnt, dn;
    px_t p;
    build(lf, rt, tp, bo, m);
    n_exp = q.size();
    @(negedge clk);
    sel = s;
    il  = X_W'(lf);
    ir  = X_W'(rt);
    it  = Y_W'(tp);
    ib  = Y_W'(bo);
    ic  = COL_W'(col);
    go  = 1'b1;
    first = -1;
    cnt = 0;
    dn = -1;
    for (int n = 1; n <= n_exp + 20 && dn < 0; n++) begin
      @(negedge clk);
      if (n == 2) begin
        il = X_W'($urandom);
        ir = X_W'($urandom);
        it = Y_W'($urandom);
        ib = Y_W'($urandom);
        ic = COL_W'($urandom);
        if (mid) go = 1'b0;
      end
      if (oplot) begin
        if (first < 0) first = n;
        cnt++;
        if (q.size() > 0) begin
          p = q.pop_front();
          chk("px_x", int'(ox), p.x);
          chk("px_y", int'(oy), p.y);
          chk("px_colour", int'(oc), col);
        end else begin
          chk("extra_plot", cnt, n_exp);
        end
      end
      if (odone) begin
        dn = n;
        chk("plot_at_done", int'(oplot), 0);
      end
    end
    chk("plot_count", cnt, n_exp);
    chk("first_plot", first, 3);
    chk("done_cycle", dn, n_exp + 3);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_done", int'(odone), 1);
      chk("hold_plot", int'(oplot), 0);
    end
    go = 1'b0;
    @(negedge clk);
    chk("done_fall", int'(odone), 0);
    chk("idle_plot", int'(oplot), 0);
    @(negedge clk);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clk);
    chk("rst_x", int'(ox), 0);
    chk("rst_y", int'(oy), 0);
    chk("rst_colour", int'(oc), 0);
    chk("rst_plot", int'(oplot), 0);
    chk("rst_done", int'(odone), 0);
    resetn = 1'b1;
    @(negedge clk);

    run_box(0, 10, 13, 20, 22, 4, 0, 0, 1'b0);
    run_box(0, 13, 10, 22, 20, 4, 0, 0, 1'b1);
    run_box(1, 0, 159, 1, 119, 7, 2, 0, 1'b0);
    run_box(0, 5, 5, 7, 7, 2, 0, 0, 1'b0);
    run_box(0, 5, 5, 0, 3, 6, 0, 0, 1'b0);
    run_box(0, 3, 8, 50, 50, 1, 0, 0, 1'b0);
    run_box(0, 3, 6, 10, 11, 3, 0, 0, 1'b0);
    run_box(1, 157, 150, 118, 100, 5, 2, 0, 1'b0);

    @(negedge clk);
    sel = 0;
    il = 8'd10;
    ir = 8'd13;
    it = 7'd20;
    ib = 7'd22;
    ic = 3'd4;
    go = 1'b1;
    seen = 0;
    for (int n = 0; n < 50 && seen < 3; n++) begin
      @(negedge clk);
      if (oplot) seen++;
    end
    chk("rst_third_plot", seen, 3);
    #2 resetn = 1'b0;
    #1;
    chk("async_plot", int'(oplot), 0);
    chk("async_done", int'(odone), 0);
    chk("async_x", int'(ox), 0);
    go = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    run_box(0, 10, 13, 20, 22, 5, 0, 0, 1'b0);

    run_box(0, 10, 13, 20, 22, 1, 0, 5, 1'b0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
